// File: rtl/alu_md.sv
// EX-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
// Base ops resolve in one cycle, MUL group in two, DIV/REM via a restoring divider.
module alu_md #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALU_Sel,
  input  logic [XLEN-1:0] operand_0,
  input  logic [XLEN-1:0] operand_1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3, OP_XOR = 5'd4,
    OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9,
    OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHSU = 5'd12, OP_MULHU = 5'd13,
    OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [XLEN:0]     r_ma, r_mb;
  logic              r_mul_hi;
  logic [XLEN-1:0]   r_quo, r_rem, r_dvsr;
  logic              r_neg_q, r_neg_r, r_rem_sel;

  logic [SW-1:0]     w_shamt;
  logic              w_accept, w_is_mul, w_is_div, w_div_signed, w_div_rem;
  logic              w_div_zero, w_div_ovf;
  logic [XLEN-1:0]   w_base, w_spec_res, w_abs0, w_abs1;
  logic [2*XLEN-1:0] w_pa, w_pb, w_prod;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_fix_q, w_fix_r;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_shamt   = operand_1[SW-1:0];

  assign w_is_mul     = (ALU_Sel >= OP_MUL) && (ALU_Sel <= OP_MULHU);
  assign w_is_div     = (ALU_Sel >= OP_DIV) && (ALU_Sel <= OP_REMU);
  assign w_div_signed = (ALU_Sel == OP_DIV) || (ALU_Sel == OP_REM);
  assign w_div_rem    = (ALU_Sel == OP_REM) || (ALU_Sel == OP_REMU);
  assign w_div_zero   = (operand_1 == '0);
  assign w_div_ovf    = w_div_signed && (operand_0 == {1'b1, {(XLEN-1){1'b0}}})
                        && (operand_1 == '1);
  assign w_spec_res   = w_div_zero ? (w_div_rem ? operand_0 : '1)
                                   : (w_div_rem ? '0 : operand_0);
  assign w_abs0 = (w_div_signed && operand_0[XLEN-1]) ? -operand_0 : operand_0;
  assign w_abs1 = (w_div_signed && operand_1[XLEN-1]) ? -operand_1 : operand_1;

  always_comb begin
    w_base = '0;
    case (ALU_Sel)
      OP_ADD:  w_base = operand_0 + operand_1;
      OP_SUB:  w_base = operand_0 - operand_1;
      OP_AND:  w_base = operand_0 & operand_1;
      OP_OR:   w_base = operand_0 | operand_1;
      OP_XOR:  w_base = operand_0 ^ operand_1;
      OP_SLL:  w_base = operand_0 << w_shamt;
      OP_SRL:  w_base = operand_0 >> w_shamt;
      OP_SRA:  w_base = $signed(operand_0) >>> w_shamt;
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(operand_0) < $signed(operand_1))};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, (operand_0 < operand_1)};
      default: w_base = '0;
    endcase
  end

  // Low 2*XLEN bits of the extended-operand product cover MUL and all MULH variants.
  assign w_pa   = {{(XLEN-1){r_ma[XLEN]}}, r_ma};
  assign w_pb   = {{(XLEN-1){r_mb[XLEN]}}, r_mb};
  assign w_prod = w_pa * w_pb;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_is_mul)                                    w_next = S_MUL;
        else if (w_is_div && !(w_div_zero || w_div_ovf)) w_next = S_DIV;
        else                                             w_next = S_DONE;
      end
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      r_cnt     <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_mul_hi  <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_is_mul) begin
            r_ma     <= {(ALU_Sel != OP_MULHU) && operand_0[XLEN-1], operand_0};
            r_mb     <= {((ALU_Sel == OP_MUL) || (ALU_Sel == OP_MULH)) && operand_1[XLEN-1],
                         operand_1};
            r_mul_hi <= (ALU_Sel != OP_MUL);
          end else if (w_is_div) begin
            if (w_div_zero || w_div_ovf) begin
              result <= w_spec_res;
            end else begin
              r_quo     <= w_abs0;
              r_rem     <= '0;
              r_dvsr    <= w_abs1;
              r_cnt     <= CW'(XLEN);
              r_neg_q   <= w_div_signed && (operand_0[XLEN-1] ^ operand_1[XLEN-1]);
              r_neg_r   <= w_div_signed && operand_0[XLEN-1];
              r_rem_sel <= w_div_rem;
            end
          end else begin
            result <= w_base;
          end
        end
        S_MUL: result <= r_mul_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        S_DIV: begin
          r_rem <= w_ge ? (w_shift[XLEN-1:0] - r_dvsr) : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: result <= r_rem_sel ? w_fix_r : w_fix_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed vector bench for alu_md: per-op result and latency, plus handshake,
// flush and reset-during-divide sequences.
module tb_alu_md;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  ALU_Sel = '0;
  logic [31:0] operand_0 = '0;
  logic [31:0] operand_1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res = '0;

  alu_md #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Sel(ALU_Sel), .operand_0(operand_0), .operand_1(operand_1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALU_Sel = op; operand_0 = a; operand_1 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALU_Sel = 5'($urandom_range(0, 31));
    operand_0 = $urandom;
    operand_1 = $urandom;
  endtask

  task automatic do_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cnt;
    logic busy_ok;
    @(negedge clk);
    chk({nm, ".ready"}, {31'd0, in_ready}, 32'd1);
    start_op(op, a, b);
    cnt = 0;
    busy_ok = 1'b1;
    while (cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
    end
    chk({nm, ".lat"}, 32'(cnt), 32'(lat));
    chk({nm, ".res"}, result, exp);
    chk({nm, ".busy"}, {31'd0, busy_ok}, 32'd1);
    last_res = exp;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, ".drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic never_valid;

    vecs.push_back('{5'd0,  32'd5,        32'd7,        32'd12,       1});
    vecs.push_back('{5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1});
    vecs.push_back('{5'd2,  32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1});
    vecs.push_back('{5'd3,  32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1});
    vecs.push_back('{5'd4,  32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1});
    vecs.push_back('{5'd5,  32'd1,        32'h0000003F, 32'h80000000, 1});
    vecs.push_back('{5'd6,  32'h80000000, 32'h00000021, 32'h40000000, 1});
    vecs.push_back('{5'd7,  32'h80000000, 32'd4,        32'hF8000000, 1});
    vecs.push_back('{5'd9,  32'd1,        32'hFFFFFFFF, 32'd1,        1});
    vecs.push_back('{5'd8,  32'd1,        32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{5'd20, 32'd123,      32'd456,      32'd0,        1});
    vecs.push_back('{5'd11, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2});
    vecs.push_back('{5'd13, 32'hFFFFFFFF, 32'd2,        32'h00000001, 2});
    vecs.push_back('{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2});
    vecs.push_back('{5'd10, 32'h00010000, 32'h00010000, 32'd0,        2});
    vecs.push_back('{5'd10, 32'd7,        32'd6,        32'd42,       2});
    vecs.push_back('{5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{5'd15, 32'd100,      32'd7,        32'd14,       34});
    vecs.push_back('{5'd17, 32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{5'd14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vecs.push_back('{5'd16, 32'd7,        32'hFFFFFFFE, 32'd1,        34});
    vecs.push_back('{5'd15, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34});
    vecs.push_back('{5'd15, 32'd9,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{5'd16, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'd0, in_ready}, 32'd0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.release_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i])
      do_op($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat);

    // Backpressure: result held, requests ignored while DONE
    start_op(5'd0, 32'd3, 32'd4);
    @(negedge clk);
    chk("bp.valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      ALU_Sel = 5'd0; operand_0 = 32'd100; operand_1 = 32'd100; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp.hold%0d.res", k), result, 32'd7);
      chk($sformatf("bp.hold%0d.ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp.hold%0d.valid", k), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp.idle.valid", {31'd0, out_valid}, 32'd0);
    chk("bp.idle.ready", {31'd0, in_ready}, 32'd1);
    chk("bp.idle.res", result, 32'd7);
    @(negedge clk);
    chk("bp.noaccept", {31'd0, out_valid}, 32'd0);
    do_op("bp.next", 5'd0, 32'd10, 32'd20, 32'd30, 1);

    // Flush mid-divide
    start_op(5'd15, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.ready", {31'd0, in_ready}, 32'd1);
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.res", result, last_res);
    never_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) never_valid = 1'b0;
    end
    chk("flush.never_valid", {31'd0, never_valid}, 32'd1);

    // Flush with request in IDLE: no accept
    ALU_Sel = 5'd0; operand_0 = 32'd1; operand_1 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle.valid", {31'd0, out_valid}, 32'd0);
    chk("flush_idle.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("flush_idle.valid2", {31'd0, out_valid}, 32'd0);

    // Reset mid-divide
    start_op(5'd14, 32'hFFFFFFF9, 32'd2);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstdiv.ready", {31'd0, in_ready}, 32'd0);
    chk("rstdiv.valid", {31'd0, out_valid}, 32'd0);
    chk("rstdiv.res", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstdiv.release_ready", {31'd0, in_ready}, 32'd1);
    chk("rstdiv.release_valid", {31'd0, out_valid}, 32'd0);
    do_op("rstdiv.add", 5'd0, 32'd1, 32'd1, 32'd2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised successor to the pipeline's combinational ALU. Keeps its opcode map for base operations and adds SLTU plus the RV32M multiply/divide group. All operations run behind a valid/ready handshake with a registered result. Divide and remainder use a multi-cycle restoring divider. Sits in the EX stage; the hazard unit stalls on `in_ready`/`out_valid` and kills in-flight work with `flush`.

## Interface
- `XLEN`, 32, operand/result width; power of two, ≥ 8; shift amount is `operand_1[$clog2(XLEN)-1:0]`
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  abort current operation, discard result
- `in_valid`  in  1  operation request
- `in_ready`  out  1  block can accept; high only in IDLE and not in reset
- `ALU_Sel`  in  5  opcode, sampled on accept
- `operand_0`, `operand_1`  in  XLEN  operands, sampled on accept
- `out_valid`  out  1  `result` valid
- `out_ready`  in  1  consumer takes result
- `result`  out  XLEN  registered result

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed)
  - 9 SLTU, 10 MUL (low XLEN), 11 MULH (s×s), 12 MULHSU (s×u), 13 MULHU (u×u)
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18–31: result 0, treated as a base op
- SLT/SLTU produce 1 or 0 zero-extended to XLEN.
- MUL group uses a 2·XLEN-bit product computed on (XLEN+1)-bit sign/zero-extended operands; MUL takes the low half, MULH* the high half.
- DIV/REM use restoring division on magnitudes. Sign fix:
  - quotient negated if operand signs differ
  - remainder takes the dividend's sign
  - unsigned ops skip the sign fix
- Special cases (resolved at accept, no iteration):
  - divisor 0: quotient all-ones; remainder = dividend
  - signed overflow (most-negative / −1): quotient = dividend; remainder 0
- FSM states:
  - IDLE: accept → BASE op goes to DONE (result written); MUL op goes to MUL; DIV/REM special case goes to DONE; other DIV/REM goes to DIV with counter = XLEN
  - MUL: product registered; next state DONE
  - DIV: one quotient bit per cycle, counter decrements; counter reaches 0 → FIX
  - FIX: sign correction, select quotient or remainder; next state DONE
  - DONE: `out_valid`=1; `out_ready` → IDLE
- `result` and `out_valid` hold stable in DONE until `out_ready`; no back-to-back accept in the DONE→IDLE cycle.
- `flush` (any state except reset) → IDLE next edge, `out_valid` low that edge, `result` unchanged; `flush` with `in_valid` in IDLE means no accept.
- `rst` overrides `flush` and all handshakes.

## Timing
- Accept is the edge where `in_valid` & `in_ready` are both 1 (edge N).
- Latency to `out_valid` rising, measured from edge N:
  - base ops and div special cases: N+1
  - MUL group: N+2
  - DIV/REM: N+XLEN+2 (34 at XLEN=32)
- Throughput: one operation per (latency+1) cycles minimum.
- Reset values: state IDLE, `out_valid` 0, `result` 0, divider counter and registers 0. `in_ready` is 0 while `rst` is high and 1 the cycle after release.
- Reset mid-divide: IDLE next edge, no `out_valid`.
- Operand changes after accept have no effect on the in-flight operation.

## Test plan
- ADD 5,7 → `result` 12, `out_valid` at N+1. SRA 0x80000000 by 4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1; SLT same operands → 0. Opcode 20 → 0.
- MULH 0xFFFFFFFF×2 → 0xFFFFFFFF. MULHU same → 0x00000001. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0x00010000×0x00010000 → 0. All at N+2.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. `out_valid` at N+34, `in_ready` low throughout.
- DIVU 9/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. All at N+1.
- Backpressure: hold `out_ready` low 5 cycles after `out_valid` → `result` stable, `in_ready` 0, new `in_valid` ignored; then `out_ready` pulse → IDLE and next accept.
- Abort: `flush` at N+10 of a DIV → IDLE at N+11, `out_valid` never rises. `rst` at N+20 of another DIV → all outputs at reset values. Next ADD 1,1 completes with result 2.
